// File: rtl/led_arb_pkg.sv
// ---------------------------------------------------------------------------
// led_arb_pkg
// Shared definitions for the LED PIO arbiter:
//   - arb_state_t   : arbiter FSM states (IDLE, WRITE, CHECK, HOLD)
//   - LED_W         : width of one LED pattern (8 bits)
//   - PIO_DATA_ADDR : address of the PIO data register (0)
// ---------------------------------------------------------------------------
package led_arb_pkg;

    localparam int         LED_W         = 8;
    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CHECK = 2'd2,
        ST_HOLD  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/led_arb_rr.sv
// ---------------------------------------------------------------------------
// led_arb_rr
// Round-robin one-hot picker. Searches i_req starting at index i_ptr and
// wrapping past NUM_REQ-1 back to 0; the first set request wins.
// Ports:
//   i_req  [NUM_REQ-1:0] : request levels
//   i_ptr  [PTR_W-1:0]   : index searched first
//   o_gnt  [NUM_REQ-1:0] : one-hot winner (all zero when no request)
// ---------------------------------------------------------------------------
module led_arb_rr #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt
);

    logic [NUM_REQ-1:0] w_rot;
    logic [NUM_REQ-1:0] w_first;

    // Rotate so the pointer position lands on bit 0; the doubled vector makes
    // the shift a rotation.
    assign w_rot   = NUM_REQ'({i_req, i_req} >> i_ptr);
    // Isolate the lowest set bit (two's complement trick).
    assign w_first = w_rot & (-w_rot);
    // Rotate the winner back into requester numbering.
    assign o_gnt   = NUM_REQ'(({w_first, w_first} << i_ptr) >> NUM_REQ);

endmodule

// File: rtl/led_pio_arbiter.sv
// ---------------------------------------------------------------------------
// led_pio_arbiter
// Shares one 8-bit LED PIO among NUM_REQ requesters. A round-robin winner is
// chosen in IDLE, its pattern written to the PIO in WRITE, optionally read back
// in CHECK, and then left on the LEDs for HOLD_CYCLES clocks in HOLD.
//
// Optional feature macro: LED_ARB_READBACK_EN
//   defined   -> CHECK state and sticky err flag compiled in
//   undefined -> no CHECK, avm_readdata ignored, err tied low
//
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   req, req_data   : per-requester level request and 8-bit pattern
//   gnt             : one-hot pulse in the WRITE cycle of the winner
//   avm_*           : Avalon-MM master to the PIO (address fixed at 0)
//   busy            : FSM not in IDLE
//   err             : sticky readback mismatch
// ---------------------------------------------------------------------------
module led_pio_arbiter
    import led_arb_pkg::*;
#(
    parameter int          NUM_REQ     = 4,
    parameter logic [31:0] HOLD_CYCLES = 32'd50000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [1:0]           avm_address,
    output logic                 avm_chipselect,
    output logic                 avm_write_n,
    output logic [31:0]          avm_writedata,
    input  logic [31:0]          avm_readdata,
    output logic                 busy,
    output logic                 err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t          r_state;
    arb_state_t          w_next;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    w_next_ptr;
    logic [NUM_REQ-1:0]  w_pick;
    logic [NUM_REQ-1:0]  r_win;
    logic [LED_W-1:0]    w_pick_data;
    logic [LED_W-1:0]    r_pattern;
    logic [31:0]         r_cnt;
    logic                w_start;
    logic                w_unused_rd;

    led_arb_rr #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick)
    );

    // A new transaction is accepted only from IDLE; later requests wait.
    assign w_start = (r_state == ST_IDLE) && (|req);

    // Winner's pattern and the pointer value just past the winner.
    always_comb begin
        w_pick_data = '0;
        w_next_ptr  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick[i]) begin
                w_pick_data = req_data[LED_W*i +: LED_W];
                w_next_ptr  = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs decode the state register directly, so reset forces them
    // to idle values immediately.
    always_comb begin
        w_next         = r_state;
        gnt            = '0;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_writedata  = '0;
        busy           = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (|req) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_writedata  = {{(32-LED_W){1'b0}}, r_pattern};
                gnt            = r_win;
`ifdef LED_ARB_READBACK_EN
                w_next         = ST_CHECK;
`else
                w_next         = ST_HOLD;
`endif
            end
`ifdef LED_ARB_READBACK_EN
            ST_CHECK: begin
                avm_chipselect = 1'b1;
                w_next         = ST_HOLD;
            end
`endif
            ST_HOLD: begin
                if (r_cnt == 32'd0) w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign avm_address = PIO_DATA_ADDR;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else begin
            if (w_start) r_ptr <= w_next_ptr;
            // Load on HOLD entry so HOLD lasts exactly HOLD_CYCLES cycles.
            if ((w_next == ST_HOLD) && (r_state != ST_HOLD)) begin
                r_cnt <= HOLD_CYCLES - 32'd1;
            end else if ((r_state == ST_HOLD) && (r_cnt != 32'd0)) begin
                r_cnt <= r_cnt - 32'd1;
            end
        end
    end

    // Winner and pattern are latched at arbitration, so a requester dropping
    // req during IDLE->WRITE still gets its pattern written.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_win     <= w_pick;
            r_pattern <= w_pick_data;
        end
    end

`ifdef LED_ARB_READBACK_EN
    logic r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if ((r_state == ST_CHECK) && (avm_readdata[LED_W-1:0] != r_pattern)) begin
            r_err <= 1'b1;
        end
    end

    assign err         = r_err;
    assign w_unused_rd = ^avm_readdata[31:LED_W];
`else
    assign err         = 1'b0;
    assign w_unused_rd = ^avm_readdata;
`endif

endmodule

// File: doc/led_pio_arbiter.md
LED_PIO_ARBITER -- requirements
Module: led_pio_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the 8-bit LED PIO.
REQ-002 Parameter HOLD_CYCLES, default 50000000, minimum clk cycles a written pattern stays on the LEDs before the next write; legal range 1..2^32-1.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  NUM_REQ  per-requester level request; held until granted.
REQ-006 req_data  input  8*NUM_REQ  pattern for requester i on bits [8i+7:8i]; stable while req[i]=1.
REQ-007 gnt  output  NUM_REQ  one-hot, one-cycle pulse in the cycle requester i's pattern is written.
REQ-008 avm_address  output  2  PIO register address; always 0.
REQ-009 avm_chipselect  output  1  PIO chip select.
REQ-010 avm_write_n  output  1  PIO write strobe, active low.
REQ-011 avm_writedata  output  32  {24'b0, pattern}.
REQ-012 avm_readdata  input  32  PIO read data; combinational in the same cycle as the access.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 err  output  1  sticky readback-mismatch flag.

Function
REQ-015 The FSM SHALL have states IDLE, WRITE, CHECK, HOLD.
REQ-016 IDLE: with any req bit set, the arbiter SHALL select the winner round-robin, starting at the index after the last grant, and go to WRITE on the next cycle.
REQ-017 WRITE: one cycle with chipselect=1, write_n=0 and writedata set to the winner's pattern; gnt[winner]=1 in that same cycle.
REQ-018 After WRITE the FSM SHALL go to CHECK when LED_ARB_READBACK_EN is defined, otherwise to HOLD.
REQ-019 CHECK: one cycle with chipselect=1, write_n=1; if avm_readdata[7:0] differs from the written pattern, err SHALL set; next state is HOLD.
REQ-020 HOLD: a 32-bit counter loads HOLD_CYCLES-1 on entry and decrements; the FSM SHALL return to IDLE in the cycle after the counter reaches 0.
REQ-021 Requests arriving during WRITE, CHECK or HOLD SHALL be queued by their level and arbitrated only in IDLE.
REQ-022 Round-robin fairness: a requester holding req continuously SHALL be granted within NUM_REQ write cycles.
REQ-023 Request-to-write latency from IDLE SHALL be exactly 1 cycle: req is sampled in cycle N and WRITE occurs in cycle N+1.
REQ-024 A requester that drops req before its grant SHALL be skipped; if the winner drops req during the IDLE-to-WRITE transition, the latched pattern is still written.
REQ-025 Outside WRITE and CHECK: chipselect=0, write_n=1, writedata=0, gnt=0.
REQ-026 The round-robin pointer SHALL wrap from NUM_REQ-1 to 0.

Reset
REQ-027 While reset=1: state=IDLE, pointer=0, counter=0, err=0, gnt=0, chipselect=0, write_n=1, writedata=0, busy=0.
REQ-028 Reset asserted mid-WRITE or mid-HOLD SHALL abort the operation immediately with no further PIO access and no gnt pulse.

Configuration
REQ-029 Macro LED_ARB_READBACK_EN defined: the CHECK state and the err logic are compiled in.
REQ-030 Macro LED_ARB_READBACK_EN undefined: CHECK is absent, avm_readdata is ignored and err is tied to 0.

Structure
REQ-031 Shared package led_arb_pkg SHALL hold the FSM state enum, the LED width constant (8) and the PIO data-register address constant (0).
REQ-032 Sub-module led_arb_rr (round-robin one-hot picker: req and pointer in, one-hot grant out) SHALL be used; the remainder is flat.

Verification
REQ-033 NUM_REQ=4, HOLD_CYCLES=4, req=4'b0001 with pattern 0xA5 -> one write of 0x000000A5 one cycle after req, gnt[0] pulses once, next write no earlier than 4 HOLD cycles later.
REQ-034 req=4'b1111 held -> grant order 0,1,2,3,0, with exactly one write per grant.
REQ-035 After the last grant to requester 2, req=4'b0101 -> grant 0 before grant 2 again; the pointer wraps correctly.
REQ-036 Reset pulsed during HOLD and during WRITE -> all outputs at reset values within the same cycle; after release, the first write occurs 1 cycle after req.
REQ-037 LED_ARB_READBACK_EN defined, readdata forced to 0x3C after a 0xC3 write -> err=1 and stays 1 until reset; without the macro err stays 0.
REQ-038 req[1] dropped while the FSM is in HOLD -> requester 1 is never granted, and other requesters proceed with no lost cycle.
